// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the inter-stage pipeline buffers: the NOP payload
// that stands in for an empty stage, IF->ID payload packing helpers, and the
// bit positions of the per-stage stall vector used by wrapper instances.
// ---------------------------------------------------------------------------
package pipe_pkg;

  // Bubble payload: pc = 0, ins = addi x0, x0, 0
  localparam logic [31:0] NOP_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  localparam int IFID_WIDTH = 64;

  // Stall vector bit positions, one per pipeline boundary
  localparam int STALL_IF  = 0;
  localparam int STALL_ID  = 1;
  localparam int STALL_EX  = 2;
  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;
  localparam int STALL_W   = 5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ifid_payload_t;

  function automatic logic [IFID_WIDTH-1:0] pack_ifid(input logic [31:0] pc,
                                                      input logic [31:0] ins);
    return {pc, ins};
  endfunction

  function automatic logic [31:0] ifid_pc(input logic [IFID_WIDTH-1:0] payload);
    return payload[63:32];
  endfunction

  function automatic logic [31:0] ifid_ins(input logic [IFID_WIDTH-1:0] payload);
    return payload[31:0];
  endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// ---------------------------------------------------------------------------
// pipe_buf_mem
// DEPTH x WIDTH storage for the stage buffer. One synchronous write port and
// one asynchronous read port so the head entry is visible in the same cycle
// the read pointer points at it. Contents are deliberately not reset; the
// owner's count decides whether an entry is meaningful.
//
// Ports:
//   clk_in   : clock, write on rising edge
//   wr_en    : write strobe
//   wr_addr  : write index
//   wr_data  : write payload
//   rd_addr  : read index
//   rd_data  : payload at rd_addr (combinational)
// ---------------------------------------------------------------------------
module pipe_buf_mem
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk_in,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
// Elastic DEPTH-entry buffer between two pipeline stages with valid/ready on
// both sides. up_ready is a function of the registered count only, so there
// is no combinational path from dn_ready (or anything else) to up_ready, and
// none from up_* to dn_*: an entry pushed into an empty buffer appears on the
// downstream side one cycle later. While empty, dn_data carries NOP_VAL so a
// consumer that ignores dn_valid still sees a bubble.
//
// Ports:
//   clk_in   : clock
//   rst_in   : asynchronous active-low reset (pointers and count only)
//   rdy_in   : chip ready; low freezes every state element
//   clear    : synchronous flush (empties buffer, discards same-cycle push/pop)
//   up_valid : producer has an entry
//   up_data  : producer payload
//   up_ready : buffer has room
//   dn_valid : head entry present
//   dn_data  : head payload, NOP_VAL when empty
//   dn_ready : consumer takes head
//   count    : number of occupied entries
// ---------------------------------------------------------------------------
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 64,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] NOP_VAL = WIDTH'({NOP_PC, NOP_INS})
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         clear,
  input  logic                         up_valid,
  input  logic [WIDTH-1:0]             up_data,
  output logic                         up_ready,
  output logic                         dn_valid,
  output logic [WIDTH-1:0]             dn_data,
  input  logic                         dn_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  // A one-entry buffer still needs a 1-bit pointer signal; it just never moves.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rd_data;

  // Wrap at DEPTH-1 explicitly so DEPTH=1 keeps the pointer pinned at 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign up_ready = (r_count != CNT_W'(DEPTH));
  assign dn_valid = (r_count != '0);
  assign count    = r_count;

  // clear and a low rdy_in both veto data movement in this cycle.
  assign w_push = up_valid & up_ready & rdy_in & ~clear;
  assign w_pop  = dn_valid & dn_ready & rdy_in & ~clear;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= ptr_inc(r_wr_ptr);
        end
        if (w_pop) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  pipe_buf_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk_in  (clk_in),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr),
    .wr_data (up_data),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_data)
  );

  assign dn_data = dn_valid ? w_rd_data : NOP_VAL;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
// Directed bench for pipe_stage_buf: a DEPTH=4 instance for fill/drain,
// flush, freeze, simultaneous push/pop and mid-run reset, and a DEPTH=2
// instance for a wrap-around run against a queue reference.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

  localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic        rdy4, clr4, uv4, ur4, dv4, dr4;
  logic [63:0] ud4, dd4;
  logic [2:0]  cnt4;

  // DEPTH=2 instance
  logic        rdy2, clr2, uv2, ur2, dv2, dr2;
  logic [63:0] ud2, dd2;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_buf #(.WIDTH(64), .DEPTH(4), .NOP_VAL(NOP)) u_dut4 (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy4), .clear(clr4),
    .up_valid(uv4), .up_data(ud4), .up_ready(ur4),
    .dn_valid(dv4), .dn_data(dd4), .dn_ready(dr4), .count(cnt4)
  );

  pipe_stage_buf #(.WIDTH(64), .DEPTH(2), .NOP_VAL(NOP)) u_dut2 (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy2), .clear(clr2),
    .up_valid(uv2), .up_data(ud2), .up_ready(ur2),
    .dn_valid(dv2), .dn_data(dd2), .dn_ready(dr2), .count(cnt2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rdy4 = 1'b1; clr4 = 1'b0; uv4 = 1'b0; dr4 = 1'b0; ud4 = '0;
    rdy2 = 1'b1; clr2 = 1'b0; uv2 = 1'b0; dr2 = 1'b0; ud2 = '0;
    #3;
    n_cmp++; if (dv4 !== 1'b0) begin n_err++; $display("FAIL reset_dn_valid: got %b expected 0", dv4); end
    n_cmp++; if (dd4 !== NOP) begin n_err++; $display("FAIL reset_dn_data: got %h expected %h", dd4, NOP); end
    n_cmp++; if (cnt4 !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", cnt4); end
    n_cmp++; if (ur4 !== 1'b1) begin n_err++; $display("FAIL reset_up_ready: got %b expected 1", ur4); end
    n_cmp++; if (cnt2 !== 2'd0) begin n_err++; $display("FAIL reset_count_d2: got %0d expected 0", cnt2); end
    step;
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_fill_drain;
    logic [63:0] seq [0:4];
    int exp_cnt [0:4] = '{3, 3, 2, 1, 0};
    seq[0] = 64'h1111_0000_0000_000A;
    seq[1] = 64'h1111_0004_0000_000B;
    seq[2] = 64'h1111_0008_0000_000C;
    seq[3] = 64'h1111_000C_0000_000D;
    seq[4] = 64'h1111_0010_0000_000E;
    dr4 = 1'b0;
    uv4 = 1'b1;
    ud4 = seq[0];
    #1;
    // Empty buffer must not pass the producer straight through.
    n_cmp++; if (dv4 !== 1'b0) begin n_err++; $display("FAIL fill_no_passthru_valid: got %b expected 0", dv4); end
    n_cmp++; if (dd4 !== NOP) begin n_err++; $display("FAIL fill_no_passthru_data: got %h expected %h", dd4, NOP); end
    for (int i = 0; i < 4; i++) begin
      ud4 = seq[i];
      step;
      $display("fill push %h", seq[i]);
      n_cmp++; if (cnt4 !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, cnt4, i + 1); end
      n_cmp++; if (dd4 !== seq[0]) begin n_err++; $display("FAIL fill_head[%0d]: got %h expected %h", i, dd4, seq[0]); end
    end
    n_cmp++; if (ur4 !== 1'b0) begin n_err++; $display("FAIL full_up_ready: got %b expected 0", ur4); end
    ud4 = seq[4];
    step;
    n_cmp++; if (cnt4 !== 3'd4) begin n_err++; $display("FAIL full_refuse_count: got %0d expected 4", cnt4); end
    dr4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      uv4 = (i < 2);
      n_cmp++; if (dd4 !== seq[i]) begin n_err++; $display("FAIL drain_head[%0d]: got %h expected %h", i, dd4, seq[i]); end
      step;
      $display("drain pop %h", seq[i]);
      n_cmp++; if (cnt4 !== 3'(exp_cnt[i])) begin n_err++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, cnt4, exp_cnt[i]); end
      if (i == 0) begin
        n_cmp++; if (ur4 !== 1'b1) begin n_err++; $display("FAIL drain_up_ready_rise: got %b expected 1", ur4); end
      end
    end
    dr4 = 1'b0;
    uv4 = 1'b0;
    n_cmp++; if (dv4 !== 1'b0) begin n_err++; $display("FAIL drain_empty_valid: got %b expected 0", dv4); end
    n_cmp++; if (dd4 !== NOP) begin n_err++; $display("FAIL drain_empty_data: got %h expected %h", dd4, NOP); end
  endtask

  task automatic test_simul;
    uv4 = 1'b1; ud4 = 64'h2222_0000_0000_0001; dr4 = 1'b0;
    step;
    ud4 = 64'h2222_0000_0000_0002; dr4 = 1'b1;
    n_cmp++; if (cnt4 !== 3'd1) begin n_err++; $display("FAIL simul_pre_count: got %0d expected 1", cnt4); end
    n_cmp++; if (dd4 !== 64'h2222_0000_0000_0001) begin n_err++; $display("FAIL simul_pre_head: got %h expected 2222000000000001", dd4); end
    step;
    $display("simul push+pop");
    n_cmp++; if (cnt4 !== 3'd1) begin n_err++; $display("FAIL simul_count: got %0d expected 1", cnt4); end
    n_cmp++; if (dd4 !== 64'h2222_0000_0000_0002) begin n_err++; $display("FAIL simul_head: got %h expected 2222000000000002", dd4); end
    uv4 = 1'b0;
    step;
    dr4 = 1'b0;
    n_cmp++; if (cnt4 !== 3'd0) begin n_err++; $display("FAIL simul_drain_count: got %0d expected 0", cnt4); end
  endtask

  task automatic test_flush;
    uv4 = 1'b1; dr4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ud4 = 64'h3333_0000_0000_0000 + 64'(i);
      step;
    end
    n_cmp++; if (cnt4 !== 3'd3) begin n_err++; $display("FAIL flush_pre_count: got %0d expected 3", cnt4); end
    clr4 = 1'b1; uv4 = 1'b1; ud4 = 64'h3333_FFFF_0000_0000; dr4 = 1'b1;
    step;
    $display("flush");
    clr4 = 1'b0; uv4 = 1'b0; dr4 = 1'b0;
    n_cmp++; if (cnt4 !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d expected 0", cnt4); end
    n_cmp++; if (dv4 !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b expected 0", dv4); end
    n_cmp++; if (dd4 !== NOP) begin n_err++; $display("FAIL flush_data: got %h expected %h", dd4, NOP); end
    n_cmp++; if (ur4 !== 1'b1) begin n_err++; $display("FAIL flush_up_ready: got %b expected 1", ur4); end
    uv4 = 1'b1; ud4 = 64'h3333_AAAA_0000_0001;
    step;
    uv4 = 1'b0;
    n_cmp++; if (cnt4 !== 3'd1) begin n_err++; $display("FAIL flush_repush_count: got %0d expected 1", cnt4); end
    n_cmp++; if (dd4 !== 64'h3333_AAAA_0000_0001) begin n_err++; $display("FAIL flush_repush_head: got %h expected 3333aaaa00000001", dd4); end
    dr4 = 1'b1;
    step;
    dr4 = 1'b0;
  endtask

  task automatic test_rdy_low;
    uv4 = 1'b1; dr4 = 1'b0;
    ud4 = 64'h4444_0000_0000_000B;
    step;
    ud4 = 64'h4444_0000_0000_000C;
    step;
    uv4 = 1'b0;
    n_cmp++; if (cnt4 !== 3'd2) begin n_err++; $display("FAIL rdy_pre_count: got %0d expected 2", cnt4); end
    rdy4 = 1'b0; uv4 = 1'b1; ud4 = 64'h4444_0000_0000_00FF; dr4 = 1'b1; clr4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      $display("frozen cycle %0d", i);
      n_cmp++; if (cnt4 !== 3'd2) begin n_err++; $display("FAIL rdy_hold_count[%0d]: got %0d expected 2", i, cnt4); end
      n_cmp++; if (dd4 !== 64'h4444_0000_0000_000B) begin n_err++; $display("FAIL rdy_hold_head[%0d]: got %h expected 444400000000000b", i, dd4); end
    end
    rdy4 = 1'b1; clr4 = 1'b0; uv4 = 1'b0; dr4 = 1'b1;
    step;
    n_cmp++; if (cnt4 !== 3'd1) begin n_err++; $display("FAIL rdy_resume_count: got %0d expected 1", cnt4); end
    n_cmp++; if (dd4 !== 64'h4444_0000_0000_000C) begin n_err++; $display("FAIL rdy_resume_head: got %h expected 444400000000000c", dd4); end
    step;
    dr4 = 1'b0;
    n_cmp++; if (cnt4 !== 3'd0) begin n_err++; $display("FAIL rdy_resume_drain: got %0d expected 0", cnt4); end
  endtask

  task automatic test_reset_mid;
    uv4 = 1'b1; dr4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ud4 = 64'h5555_0000_0000_0000 + 64'(i);
      step;
    end
    uv4 = 1'b0;
    n_cmp++; if (cnt4 !== 3'd3) begin n_err++; $display("FAIL rstmid_pre_count: got %0d expected 3", cnt4); end
    rst_n = 1'b0;
    #2;
    $display("reset mid-operation");
    n_cmp++; if (dv4 !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", dv4); end
    n_cmp++; if (dd4 !== NOP) begin n_err++; $display("FAIL rstmid_data: got %h expected %h", dd4, NOP); end
    n_cmp++; if (cnt4 !== 3'd0) begin n_err++; $display("FAIL rstmid_count: got %0d expected 0", cnt4); end
    n_cmp++; if (ur4 !== 1'b1) begin n_err++; $display("FAIL rstmid_up_ready: got %b expected 1", ur4); end
    rst_n = 1'b1;
    uv4 = 1'b1; ud4 = 64'h5555_BEEF_0000_0001;
    step;
    uv4 = 1'b0;
    n_cmp++; if (cnt4 !== 3'd1) begin n_err++; $display("FAIL rstmid_first_push: got %0d expected 1", cnt4); end
    n_cmp++; if (dd4 !== 64'h5555_BEEF_0000_0001) begin n_err++; $display("FAIL rstmid_first_head: got %h expected 5555beef00000001", dd4); end
    dr4 = 1'b1;
    step;
    dr4 = 1'b0;
  endtask

  task automatic test_wrap;
    logic [63:0] q [$];
    int   sent = 0;
    int   got  = 0;
    int   cyc  = 0;
    logic e_push, e_pop, e_valid, e_ready;
    while (got < 10 && cyc < 200) begin
      uv2 = (sent < 10);
      ud2 = 64'h6666_0000_0000_0000 + 64'(sent);
      dr2 = 1'($urandom_range(0, 1));
      e_valid = (q.size() != 0);
      e_ready = (q.size() != 2);
      n_cmp++; if (dv2 !== e_valid) begin n_err++; $display("FAIL wrap_valid cyc %0d: got %b expected %b", cyc, dv2, e_valid); end
      n_cmp++; if (ur2 !== e_ready) begin n_err++; $display("FAIL wrap_up_ready cyc %0d: got %b expected %b", cyc, ur2, e_ready); end
      if (e_valid) begin
        n_cmp++; if (dd2 !== q[0]) begin n_err++; $display("FAIL wrap_head cyc %0d: got %h expected %h", cyc, dd2, q[0]); end
      end
      e_push = uv2 & e_ready;
      e_pop  = dr2 & e_valid;
      step;
      cyc++;
      if (e_pop) begin
        $display("wrap pop %0d data %h", got, q[0]);
        void'(q.pop_front());
        got++;
      end
      if (e_push) begin
        q.push_back(ud2);
        sent++;
      end
      n_cmp++; if (cnt2 !== 2'(q.size())) begin n_err++; $display("FAIL wrap_count cyc %0d: got %0d expected %0d", cyc, cnt2, q.size()); end
      n_cmp++; if (cnt2 > 2'd2) begin n_err++; $display("FAIL wrap_count_bound cyc %0d: got %0d expected <=2", cyc, cnt2); end
    end
    uv2 = 1'b0;
    dr2 = 1'b0;
    n_cmp++; if (got != 10) begin n_err++; $display("FAIL wrap_timeout: got %0d entries expected 10", got); end
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_simul;
    test_flush;
    test_rdy_low;
    test_reset_mid;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
